// File: rtl/bus_arbiter_if.sv
// Bus-side signal bundle for the two-master round-robin arbiter.
// The master modport is the arbiter's view; the slave modport is the requester/slave-side view.
interface bus_arbiter_if;
    logic       m1_req;
    logic       m2_req;
    logic [1:0] m1_slave_id;
    logic [1:0] m2_slave_id;
    logic       bus_done;
    logic       m1_grant;
    logic       m2_grant;
    logic [2:0] slave_sel;
    logic       bus_busy;
    logic       dec_err;
    logic       timeout_err;

    modport master (
        input  m1_req, m2_req, m1_slave_id, m2_slave_id, bus_done,
        output m1_grant, m2_grant, slave_sel, bus_busy, dec_err, timeout_err
    );

    modport slave (
        output m1_req, m2_req, m1_slave_id, m2_slave_id, bus_done,
        input  m1_grant, m2_grant, slave_sel, bus_busy, dec_err, timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner of the serial system bus for two masters and three slaves.
// Optional BUSY watchdog with forced release is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 16
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Masters are encoded 0 = M1, 1 = M2 for owner bookkeeping.
    state_t     state_r;
    logic       last_owner_r;
    logic       owner_r;
    logic       m1_grant_r;
    logic       m2_grant_r;
    logic [2:0] slave_sel_r;
    logic       bus_busy_r;
    logic       dec_err_r;
    logic       timeout_err_r;

    logic       any_req_s;
    logic       winner_s;
    logic [1:0] win_id_s;
    logic       owner_req_s;
    logic       timeout_hit_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wdog_r;
`endif

    function automatic logic [2:0] id_to_sel(input logic [1:0] id);
        logic [2:0] sel;
        case (id)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    // Winner selection and release-condition decode
    always_comb begin
        any_req_s   = bus.m1_req | bus.m2_req;
        winner_s    = 1'b0;
        if (bus.m1_req && bus.m2_req) begin
            winner_s = ~last_owner_r;
        end else if (bus.m2_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        win_id_s    = winner_s ? bus.m2_slave_id : bus.m1_slave_id;
        owner_req_s = owner_r ? bus.m2_req : bus.m1_req;
`ifdef ARB_TIMEOUT_EN
        timeout_hit_s = (wdog_r == WDOG_LAST);
`else
        timeout_hit_s = 1'b0;
`endif
    end

    // Arbitration state machine with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            last_owner_r  <= 1'b1;
            owner_r       <= 1'b0;
            m1_grant_r    <= 1'b0;
            m2_grant_r    <= 1'b0;
            slave_sel_r   <= 3'b000;
            bus_busy_r    <= 1'b0;
            dec_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wdog_r        <= '0;
`endif
        end else begin
            dec_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        // A bad id still rotates priority so a stuck requester cannot starve its peer.
                        last_owner_r <= winner_s;
                        if (win_id_s == 2'd3) begin
                            dec_err_r <= 1'b1;
                            state_r   <= RELEASE;
                        end else begin
                            owner_r     <= winner_s;
                            m1_grant_r  <= ~winner_s;
                            m2_grant_r  <= winner_s;
                            slave_sel_r <= id_to_sel(win_id_s);
                            bus_busy_r  <= 1'b1;
                            state_r     <= GRANT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
`ifdef ARB_TIMEOUT_EN
                    wdog_r  <= '0;
`endif
                    state_r <= BUSY;
                end
                BUSY: begin
                    if (bus.bus_done || !owner_req_s || timeout_hit_s) begin
                        m1_grant_r    <= 1'b0;
                        m2_grant_r    <= 1'b0;
                        slave_sel_r   <= 3'b000;
                        bus_busy_r    <= 1'b0;
                        timeout_err_r <= timeout_hit_s & ~bus.bus_done & owner_req_s;
                        state_r       <= RELEASE;
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        wdog_r  <= wdog_r + CNT_W'(1);
`endif
                        state_r <= BUSY;
                    end
                end
                RELEASE: begin
                    state_r <= IDLE;
                end
                default: begin
                    m1_grant_r  <= 1'b0;
                    m2_grant_r  <= 1'b0;
                    slave_sel_r <= 3'b000;
                    bus_busy_r  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.m1_grant    = m1_grant_r;
    assign bus.m2_grant    = m2_grant_r;
    assign bus.slave_sel   = slave_sel_r;
    assign bus.bus_busy    = bus_busy_r;
    assign bus.dec_err     = dec_err_r;
    assign bus.timeout_err = timeout_err_r;

endmodule
